// File: rtl/reset_synchronizer.sv
// Root reset conditioner for one clock domain: asserts on the next edge, releases only after
// RST has been sampled low for NUM_STAGES + HOLD_CYCLES consecutive edges.
module reset_synchronizer #(
   parameter int unsigned NUM_STAGES  = 2,
   parameter int unsigned HOLD_CYCLES = 0
) (
   input  logic CLK,
   input  logic RST,
   output logic SYNC_RST,
   output logic SYNC_RST_N,
   output logic RST_DONE
);

   localparam int unsigned CntW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [CntW-1:0] HoldInit = CntW'(HOLD_CYCLES);

   if (NUM_STAGES < 2 || NUM_STAGES > 16) begin : g_bad_stages
      $error("reset_synchronizer: NUM_STAGES must be in 2..16");
   end
   if (HOLD_CYCLES > 255) begin : g_bad_hold
      $error("reset_synchronizer: HOLD_CYCLES must be in 0..255");
   end

   logic [NUM_STAGES-1:0] chain_q, chain_d;
   logic [CntW-1:0]       hold_cnt_q, hold_cnt_d;
   logic                  sync_rst_d;

   always_comb begin
      chain_d    = {chain_q[NUM_STAGES-2:0], 1'b0};
      hold_cnt_d = hold_cnt_q;
      if (!chain_q[NUM_STAGES-1] && (hold_cnt_q != '0)) begin
         hold_cnt_d = hold_cnt_q - CntW'(1);
      end
      // Look at next-state values so release lands on edge NUM_STAGES + HOLD_CYCLES exactly.
      sync_rst_d = chain_d[NUM_STAGES-1] | (hold_cnt_d != '0);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         chain_q    <= '1;
         hold_cnt_q <= HoldInit;
         SYNC_RST   <= 1'b1;
         SYNC_RST_N <= 1'b0;
         RST_DONE   <= 1'b0;
      end else begin
         chain_q    <= chain_d;
         hold_cnt_q <= hold_cnt_d;
         SYNC_RST   <= sync_rst_d;
         SYNC_RST_N <= ~sync_rst_d;
         RST_DONE   <= SYNC_RST & ~sync_rst_d;
      end
   end

endmodule

// File: tb/tb_reset_synchronizer.sv
// Bench for reset_synchronizer: directed scenarios plus random RST against a run-length model.
module tb_reset_synchronizer;

   localparam int unsigned NA = 4, HA = 0;
   localparam int unsigned NB = 2, HB = 3;
   localparam int unsigned NC = 5, HC = 7;

   logic clk, rst;
   logic sync_a, syncn_a, done_a;
   logic sync_b, syncn_b, done_b;
   logic sync_c, syncn_c, done_c;
   int   checks, failures;
   int   low_run;

   reset_synchronizer #(.NUM_STAGES(NA), .HOLD_CYCLES(HA)) u_a (
      .CLK(clk), .RST(rst), .SYNC_RST(sync_a), .SYNC_RST_N(syncn_a), .RST_DONE(done_a)
   );
   reset_synchronizer #(.NUM_STAGES(NB), .HOLD_CYCLES(HB)) u_b (
      .CLK(clk), .RST(rst), .SYNC_RST(sync_b), .SYNC_RST_N(syncn_b), .RST_DONE(done_b)
   );
   reset_synchronizer #(.NUM_STAGES(NC), .HOLD_CYCLES(HC)) u_c (
      .CLK(clk), .RST(rst), .SYNC_RST(sync_c), .SYNC_RST_N(syncn_c), .RST_DONE(done_c)
   );

   always #5 clk = ~clk;

   // Reference: number of consecutive edges that sampled RST low.
   always @(posedge clk) begin
      if (rst) low_run <= 0;
      else if (low_run < 100000) low_run <= low_run + 1;
   end

   task automatic step(input logic v);
      @(negedge clk);
      rst = v;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b1);
      checks++;
      if (sync_a !== 1'b1 || syncn_a !== 1'b0 || done_a !== 1'b0) begin
         failures++;
         $display("FAIL reset_first_edge: got sync=%b n=%b done=%b, want 1 0 0",
                  sync_a, syncn_a, done_a);
      end
      step(1'b1);
      checks++;
      if (sync_a !== 1'b1 || syncn_a !== 1'b0 || done_a !== 1'b0) begin
         failures++;
         $display("FAIL reset_second_edge: got sync=%b n=%b done=%b, want 1 0 0",
                  sync_a, syncn_a, done_a);
      end
   endtask

   task automatic test_release();
      for (int k = 1; k <= 6; k++) begin
         logic es, ed;
         step(1'b0);
         es = (k < 4);
         ed = (k == 4);
         checks++;
         if (sync_a !== es || syncn_a !== ~es || done_a !== ed) begin
            failures++;
            $display("FAIL release_edge%0d: got sync=%b n=%b done=%b, want %b %b %b",
                     k, sync_a, syncn_a, done_a, es, ~es, ed);
         end
      end
   endtask

   task automatic test_glitch();
      step(1'b1);
      step(1'b0);
      step(1'b0);
      step(1'b1);
      checks++;
      if (sync_a !== 1'b1 || done_a !== 1'b0) begin
         failures++;
         $display("FAIL glitch_hold: got sync=%b done=%b, want 1 0", sync_a, done_a);
      end
      for (int k = 1; k <= 4; k++) begin
         step(1'b0);
         checks++;
         if (sync_a !== (k < 4) || done_a !== (k == 4)) begin
            failures++;
            $display("FAIL glitch_release_edge%0d: got sync=%b done=%b, want %b %b",
                     k, sync_a, done_a, (k < 4), (k == 4));
         end
      end
   endtask

   task automatic test_hold();
      step(1'b1);
      for (int k = 1; k <= 7; k++) begin
         step(1'b0);
         checks++;
         if (sync_b !== (k < 5) || syncn_b !== (k >= 5) || done_b !== (k == 5)) begin
            failures++;
            $display("FAIL hold_edge%0d: got sync=%b n=%b done=%b, want %b %b %b",
                     k, sync_b, syncn_b, done_b, (k < 5), (k >= 5), (k == 5));
         end
      end
      step(1'b1);
      for (int k = 1; k <= 3; k++) step(1'b0);
      step(1'b1);
      checks++;
      if (sync_b !== 1'b1 || done_b !== 1'b0) begin
         failures++;
         $display("FAIL hold_reassert: got sync=%b done=%b, want 1 0", sync_b, done_b);
      end
      // Full 5-edge release again shows the hold count was reloaded.
      for (int k = 1; k <= 5; k++) begin
         step(1'b0);
         checks++;
         if (sync_b !== (k < 5) || done_b !== (k == 5)) begin
            failures++;
            $display("FAIL hold_reload_edge%0d: got sync=%b done=%b, want %b %b",
                     k, sync_b, done_b, (k < 5), (k == 5));
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 2; r++) begin
         int pulses;
         step(1'b1);
         checks++;
         if (sync_a !== 1'b1 || syncn_a !== 1'b0 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL b2b_assert%0d: got sync=%b n=%b done=%b, want 1 0 0",
                     r, sync_a, syncn_a, done_a);
         end
         pulses = 0;
         for (int k = 1; k <= 6; k++) begin
            step(1'b0);
            if (done_a === 1'b1) pulses++;
            checks++;
            if (sync_a !== (k < 4)) begin
               failures++;
               $display("FAIL b2b_release%0d_edge%0d: got sync=%b, want %b",
                        r, k, sync_a, (k < 4));
            end
         end
         checks++;
         if (pulses != 1) begin
            failures++;
            $display("FAIL b2b_done_pulses%0d: got %0d, want 1", r, pulses);
         end
      end
   endtask

   task automatic test_random();
      int cycles;
      cycles = 0;
      step(1'b1);
      while (cycles < 1000) begin
         logic v;
         int   len;
         v   = ($urandom_range(0, 3) == 0);
         len = v ? $urandom_range(1, 3) : $urandom_range(1, 16);
         for (int i = 0; i < len; i++) begin
            logic ea, eb, ec;
            step(v);
            cycles++;
            ea = (low_run < int'(NA + HA));
            eb = (low_run < int'(NB + HB));
            ec = (low_run < int'(NC + HC));
            checks++;
            if (sync_a !== ea || syncn_a !== ~ea || done_a !== (low_run == int'(NA + HA))) begin
               failures++;
               $display("FAIL rand_a cyc%0d: got sync=%b n=%b done=%b, want %b %b %b",
                        cycles, sync_a, syncn_a, done_a, ea, ~ea, low_run == int'(NA + HA));
            end
            checks++;
            if (sync_b !== eb || syncn_b !== ~eb || done_b !== (low_run == int'(NB + HB))) begin
               failures++;
               $display("FAIL rand_b cyc%0d: got sync=%b n=%b done=%b, want %b %b %b",
                        cycles, sync_b, syncn_b, done_b, eb, ~eb, low_run == int'(NB + HB));
            end
            checks++;
            if (sync_c !== ec || syncn_c !== ~ec || done_c !== (low_run == int'(NC + HC))) begin
               failures++;
               $display("FAIL rand_c cyc%0d: got sync=%b n=%b done=%b, want %b %b %b",
                        cycles, sync_c, syncn_c, done_c, ec, ~ec, low_run == int'(NC + HC));
            end
         end
      end
   endtask

   initial begin
      clk      = 1'b0;
      rst      = 1'b1;
      low_run  = 0;
      checks   = 0;
      failures = 0;
      test_reset();
      test_release();
      test_glitch();
      test_hold();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
